mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the ALU in the execute stage. It consumes the funct3 selection and operands that the ALU controller path decodes for M-extension R-type instructions (funct7 = 0000001). It produces a 32-bit result after a fixed 32-cycle latency and drives `busy` so the hazard logic stalls the pipeline. It is a multi-cycle state machine, not combinational.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/mul_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the M-extension multiply/divide unit:
// funct3 encodings, FSM states and sign pre/post-correction helpers.
package riscv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Magnitude of x when it is treated as signed, otherwise x unchanged.
    function automatic logic [31:0] abs_sel(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] neg_sel(input logic [63:0] x, input logic neg);
        return neg ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32 iterations per operation,
// shift-add multiply and restoring divide sharing one 64-bit work register.
module mul_div_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state_o
);

    mdu_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    mdu_op_e     op_q, op_d;
    logic [63:0] work_q, work_d;
    logic [31:0] oper_q, oper_d;
    logic        neg_q, neg_d;
    logic        special_q, special_d;
    logic [31:0] spec_val_q, spec_val_d;
    logic [31:0] result_q, result_d;

    // Start-time decode of the incoming request.
    logic        a_signed, b_signed, in_div, in_rem, div_zero, div_ovf;
    logic [31:0] a_mag, b_mag;
    logic [63:0] ld_work;
    logic [31:0] ld_oper, ld_spec_val;
    logic        ld_neg, ld_special;

    always_comb begin
        a_signed    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        in_div      = op[2];
        in_rem      = op[2] & op[1];
        a_mag       = abs_sel(rs1, a_signed);
        b_mag       = abs_sel(rs2, b_signed);
        div_zero    = (rs2 == 32'd0);
        div_ovf     = !op[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
        ld_work     = in_div ? {32'd0, a_mag} : {32'd0, b_mag};
        ld_oper     = in_div ? b_mag : a_mag;
        // Remainder follows the dividend; products and quotients follow the sign xor.
        ld_neg      = in_rem ? (a_signed & rs1[31])
                             : ((a_signed & rs1[31]) ^ (b_signed & rs2[31]));
        ld_special  = in_div && (div_zero || div_ovf);
        if (div_zero) begin
            ld_spec_val = in_rem ? rs1 : 32'hFFFF_FFFF;
        end else begin
            ld_spec_val = in_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration of the datapath and the corrected final value.
    logic [32:0] mul_sum, rem_shift, div_diff;
    logic [63:0] mul_next, div_next, iter_next, sel64, cor64;
    logic        div_ge, hi_sel, rem_sel;
    logic [31:0] fin_val;

    always_comb begin
        mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, oper_q} : 33'd0);
        mul_next  = {mul_sum, work_q[31:1]};
        rem_shift = work_q[63:31];
        div_diff  = rem_shift - {1'b0, oper_q};
        div_ge    = ~div_diff[32];
        div_next  = {div_ge ? div_diff[31:0] : rem_shift[31:0], work_q[30:0], div_ge};
        iter_next = op_q[2] ? div_next : mul_next;
        hi_sel    = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_MULHU);
        rem_sel   = op_q[2] & op_q[1];
        if (op_q[2]) begin
            sel64 = {32'd0, rem_sel ? iter_next[63:32] : iter_next[31:0]};
        end else begin
            sel64 = iter_next;
        end
        cor64   = neg_sel(sel64, neg_q);
        if (special_q) begin
            fin_val = spec_val_q;
        end else begin
            fin_val = hi_sel ? cor64[63:32] : cor64[31:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        work_d     = work_q;
        oper_d     = oper_q;
        neg_d      = neg_q;
        special_d  = special_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_CALC;
                    cnt_d      = 5'd0;
                    op_d       = mdu_op_e'(op);
                    work_d     = ld_work;
                    oper_d     = ld_oper;
                    neg_d      = ld_neg;
                    special_d  = ld_special;
                    spec_val_d = ld_spec_val;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                work_d = iter_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = fin_val;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over start and over completion; result is left untouched.
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            op_q       <= OP_MUL;
            work_q     <= 64'd0;
            oper_q     <= 32'd0;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_val_q <= 32'd0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            work_q     <= work_d;
            oper_q     <= oper_d;
            neg_q      <= neg_d;
            special_q  <= special_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
        end
    end

    assign busy        = (state_q == ST_CALC);
    assign done        = (state_q == ST_DONE);
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: fixed latency, arithmetic results,
// special cases, flush, asynchronous reset, start-during-CALC and back-to-back.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int tests;
    int fails;

    mul_div_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs1         (rs1),
        .rs2         (rs2),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at E0 + 1 with inputs scrambled.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        rs1   = $urandom;
        rs2   = $urandom;
    endtask

    // Counts cycles until done (bounded); optionally pulses start at cycle pulse_at.
    task automatic wait_done(input int pulse_at, output int cyc, output int busy_cyc, output int overlap);
        bit seen;
        cyc = 0; busy_cyc = 0; overlap = 0; seen = 0;
        while (!seen && cyc < 40) begin
            if (busy) busy_cyc++;
            if (busy && done) overlap++;
            if (done) begin
                seen = 1;
            end else begin
                start = (cyc == pulse_at);
                @(posedge clk);
                #1;
                start = 1'b0;
                cyc++;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc, bc, ov;
        launch(o, a, b);
        wait_done(-1, cyc, bc, ov);
        check({tag, "_latency"}, 32'(cyc), 32'd32);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd32);
        check({tag, "_overlap"}, 32'(ov), 32'd0);
        check({tag, "_result"}, result, exp);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc, bc, ov, dn;
        tests = 0; fails = 0;
        reset = 1'b0; start = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0; flush = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2);
        run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

        // Flush at CALC cycle 10: idle next edge, no done, result kept.
        launch(3'b000, 32'd3, 32'd4);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_state", {30'd0, dbg_state}, 32'd0);
        check("flush_result", result, 32'h8000_0000);
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("flush_no_done", 32'(dn), 32'd0);

        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("mul_small", 3'b000, 32'd3, 32'd4, 32'd12);

        // Asynchronous reset at CALC cycle 20.
        launch(3'b101, 32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Start pulsed mid-CALC is ignored: one done with the first result.
        launch(3'b101, 32'd100, 32'd7);
        rs1 = 32'd9; rs2 = 32'd3; op = 3'b000;
        wait_done(5, cyc, bc, ov);
        check("ign_latency", 32'(cyc), 32'd32);
        check("ign_result", result, 32'd14);
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("ign_single_done", 32'(dn), 32'd0);

        // Back-to-back: start held in the DONE cycle.
        launch(3'b111, 32'd100, 32'd7);
        wait_done(-1, cyc, bc, ov);
        check("b2b1_latency", 32'(cyc), 32'd32);
        check("b2b1_result", result, 32'd2);
        start = 1'b1; op = 3'b000; rs1 = 32'd6; rs2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; rs1 = $urandom; rs2 = $urandom;
        check("b2b_busy_rerise", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        check("b2b_result_hold", result, 32'd2);
        wait_done(-1, cyc, bc, ov);
        check("b2b2_latency", 32'(cyc), 32'd32);
        check("b2b2_overlap", 32'(ov), 32'd0);
        check("b2b2_result", result, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
